// File: rtl/ap_mult_pkg.sv
// Shared helpers for the approximate unsigned multiplier family.
// Truncation clamping, compensation constant and result-width helper.
package ap_mult_pkg;

    function automatic int pw_of(input int dw);
        return 2 * dw;
    endfunction

    function automatic int clamp_k(input int k, input int k_max);
        return (k > k_max) ? k_max : k;
    endfunction

    // Half of the weight of the lowest kept column, centring the truncation error.
    function automatic logic [63:0] comp_const(input int keff, input int width);
        if (keff <= 0 || keff > width)
            return '0;
        return 64'd1 << (keff - 1);
    endfunction

endpackage

// File: rtl/ap_wall_csa_tree.sv
// Combinational Wallace reduction of DW partial-product rows to two rows.
// Each level compresses row triples with 3:2 counters; leftovers pass through.
module ap_wall_csa_tree
    import ap_mult_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic [DW*DW-1:0] pp,
    output logic [2*DW-1:0]  sum,
    output logic [2*DW-1:0]  carry
);

    localparam int PW = pw_of(DW);

    function automatic int levels(input int n0);
        int n;
        int l;
        n = n0;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LV = levels(DW);

    logic [PW-1:0] cur [DW];
    logic [PW-1:0] nxt [DW];
    int n;
    int m;

    always_comb begin
        n = DW;
        m = 0;
        for (int r = 0; r < DW; r++)
            cur[r] = {{DW{1'b0}}, pp[r*DW +: DW]} << r;
        for (int r = 0; r < DW; r++)
            nxt[r] = '0;
        for (int l = 0; l < LV; l++) begin
            for (int r = 0; r < DW; r++)
                nxt[r] = '0;
            for (int g = 0; g < DW / 3; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[2*g] = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                    nxt[2*g+1] = ((cur[3*g] & cur[3*g+1])
                                | (cur[3*g] & cur[3*g+2])
                                | (cur[3*g+1] & cur[3*g+2])) << 1;
                end
            end
            m = 2 * (n / 3);
            for (int t = 0; t < 2; t++) begin
                if (3 * (n / 3) + t < n)
                    nxt[m+t] = cur[3*(n/3)+t];
            end
            n = m + n % 3;
            for (int r = 0; r < DW; r++)
                cur[r] = nxt[r];
        end
        sum = cur[0];
        carry = cur[1];
    end

endmodule

// File: rtl/ap_unsi_wall_pipe.sv
// Three-stage pipelined approximate unsigned Wallace multiplier.
// Low-column truncation with run-time k and constant compensation.
module ap_unsi_wall_pipe
    import ap_mult_pkg::*;
#(
    parameter int DW = 12,
    parameter int K_MAX = 8,
    parameter int KW = $clog2(K_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   muld,
    input  logic [DW-1:0]   mulr,
    input  logic [KW-1:0]   approx_k,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] res,
    output logic [KW-1:0]   res_k
);

    localparam int PW = pw_of(DW);

    logic            adv;
    logic            v1;
    logic            v2;
    logic [DW-1:0]   a1;
    logic [DW-1:0]   b1;
    logic [KW-1:0]   k1;
    logic [KW-1:0]   k2;
    logic [DW*DW-1:0] pp;
    logic [PW-1:0]   sum_c;
    logic [PW-1:0]   cry_c;
    logic [PW-1:0]   sum2;
    logic [PW-1:0]   cry2;

    // Whole-pipe stall: nothing moves while a result waits.
    assign adv = !out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            a1 <= muld;
            b1 <= mulr;
            k1 <= KW'(clamp_k(int'(approx_k), K_MAX));
        end
    end

    for (genvar j = 0; j < DW; j++) begin : g_row
        for (genvar i = 0; i < DW; i++) begin : g_col
            assign pp[j*DW+i] = a1[i] & b1[j] & ((i + j) >= int'(k1));
        end
    end

    ap_wall_csa_tree #(
        .DW(DW)
    ) u_tree (
        .pp(pp),
        .sum(sum_c),
        .carry(cry_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            sum2 <= sum_c;
            cry2 <= cry_c;
            k2 <= k1;
        end
    end

    // Outputs only change on a valid result so idle cycles keep res stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res <= '0;
            res_k <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                res <= sum2 + cry2 + PW'(comp_const(int'(k2), PW));
                res_k <= k2;
            end
        end
    end

endmodule
